// File: rtl/tick_scheduler.sv
// Tick scheduler: free-running prescaler giving base_tick, four programmable periodic tick channels,
// and a one-deep config port whose period writes land on the next base_tick boundary.
module tick_scheduler #(
  parameter int PRESCALE = 100,
  parameter int PW       = 16
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_ch,
  input  logic [PW-1:0] cfg_period,
  output logic          cfg_ready,
  output logic          cfg_ack,
  input  logic [3:0]    ch_en,
  output logic          base_tick,
  output logic [3:0]    tick_out
);

  localparam logic [15:0]   PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE      = PW'(1);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  state_t        state_q, state_d;
  logic [15:0]   pre_cnt_q, pre_cnt_d;
  logic          base_tick_q, base_tick_d;
  logic [3:0]    tick_q, tick_d;
  logic [1:0]    hold_ch_q, hold_ch_d;
  logic [PW-1:0] hold_period_q, hold_period_d;
  logic [PW-1:0] period_q [4];
  logic [PW-1:0] period_d [4];
  logic [PW-1:0] cnt_q [4];
  logic [PW-1:0] cnt_d [4];
  logic          apply;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= IDLE;
      pre_cnt_q     <= '0;
      base_tick_q   <= 1'b0;
      tick_q        <= '0;
      hold_ch_q     <= '0;
      hold_period_q <= '0;
      for (int i = 0; i < 4; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      base_tick_q   <= base_tick_d;
      tick_q        <= tick_d;
      hold_ch_q     <= hold_ch_d;
      hold_period_q <= hold_period_d;
      period_q      <= period_d;
      cnt_q         <= cnt_d;
    end
  end

  // Prescaler free-runs; base_tick is the registered wrap of pre_cnt.
  always_comb begin
    base_tick_d = (pre_cnt_q == PRE_LAST);
    pre_cnt_d   = base_tick_d ? '0 : pre_cnt_q + 16'd1;
  end

  always_comb begin
    state_d       = state_q;
    hold_ch_d     = hold_ch_q;
    hold_period_d = hold_period_q;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          state_d       = PEND;
          hold_ch_d     = cfg_ch;
          hold_period_d = cfg_period;
        end
      end
      PEND:    if (base_tick_q) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == IDLE);
    cfg_ack   = (state_q == ACK);
    apply     = (state_q == PEND) && base_tick_q;
  end

  // An applied write restarts its channel and swallows that channel's tick for this base_tick.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      tick_d[i]   = 1'b0;
      if (apply && (hold_ch_q == 2'(i))) begin
        period_d[i] = hold_period_q;
        cnt_d[i]    = '0;
      end else if (!ch_en[i] || (period_q[i] == '0)) begin
        cnt_d[i] = '0;
      end else if (base_tick_q) begin
        if (cnt_q[i] == period_q[i] - ONE) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
    end
  end

  assign base_tick = base_tick_q;
  assign tick_out  = tick_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler (PRESCALE=4, PW=16): directed table and sequences plus random traffic,
// every cycle compared against a progress-count reference model.
module tb_tick_scheduler;
  localparam int PRESCALE = 4;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        cfg_ready;
  logic        cfg_ack;
  logic [3:0]  ch_en;
  logic        base_tick;
  logic [3:0]  tick_out;

  tick_scheduler #(.PRESCALE(PRESCALE), .PW(16)) dut (
    .clk_in(clk_in), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_ready(cfg_ready), .cfg_ack(cfg_ack), .ch_en(ch_en), .base_tick(base_tick), .tick_out(tick_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick[4];
  int prev_tick[4];
  int ntick[4];
  int nack = 0;
  int nocoinc = 0;

  // Reference model: time since release, and base ticks counted per channel since its last restart.
  int          t;
  logic        m_base, m_pend, m_ack;
  logic [3:0]  m_tick;
  logic [1:0]  m_hch;
  logic [15:0] m_hper;
  int          m_per[4];
  int          m_prog[4];

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] per;
    logic [3:0]  en;
    int          interval;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_step();
    logic       apply;
    logic [3:0] nt;
    if (rst) begin
      t = 0; m_base = 0; m_pend = 0; m_ack = 0; m_tick = '0;
      for (int i = 0; i < 4; i++) begin m_per[i] = 0; m_prog[i] = 0; end
    end else begin
      apply = m_pend && m_base;
      nt = '0;
      for (int i = 0; i < 4; i++) begin
        if (apply && int'(m_hch) == i) begin
          m_per[i] = int'(m_hper); m_prog[i] = 0;
        end else if (!ch_en[i] || m_per[i] == 0) begin
          m_prog[i] = 0;
        end else if (m_base) begin
          m_prog[i]++;
          nt[i] = (m_prog[i] % m_per[i] == 0);
        end
      end
      if (!m_pend && !m_ack && cfg_we) begin
        m_pend = 1; m_hch = cfg_ch; m_hper = cfg_period;
      end else if (apply) begin
        m_pend = 0;
      end
      m_ack  = apply;
      t++;
      m_base = (t % PRESCALE == 0);
      m_tick = nt;
    end
  endtask

  task automatic tick_cycle();
    logic [6:0] got, exp;
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
    got = {base_tick, tick_out, cfg_ready, cfg_ack};
    exp = {m_base, m_tick, !m_pend && !m_ack, m_ack};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model cyc=%0d got=%b exp=%b", cyc, got, exp);
    end
    for (int i = 0; i < 4; i++)
      if (tick_out[i]) begin prev_tick[i] = last_tick[i]; last_tick[i] = cyc; ntick[i]++; end
    if (cfg_ack) nack++;
    if (tick_out[2] && !tick_out[1]) nocoinc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick_cycle();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin ntick[i] = 0; last_tick[i] = -100000; prev_tick[i] = -100000; end
    nack = 0;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!cfg_ready && g < 20) begin tick_cycle(); g++; end
    check("wait_ready", int'(cfg_ready), 1);
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [15:0] per);
    int   bases = 0;
    logic got_ack = 0;
    logic prev_base = 0;
    wait_ready();
    cfg_we = 1; cfg_ch = ch; cfg_period = per;
    tick_cycle();
    cfg_we = 0;
    for (int g = 0; g < 16 && !got_ack; g++) begin
      if (cfg_ack) got_ack = 1;
      else begin bases += int'(base_tick); prev_base = base_tick; tick_cycle(); end
    end
    check("ack_seen", int'(got_ack), 1);
    check("ack_bases", bases, 1);
    check("ack_after_base", int'(prev_base), 1);
  endtask

  initial begin
    int   bmask;
    int   bases;
    int   g;
    logic prev_base;

    vecs[0] = '{2'd0, 16'd3, 4'b0001, 12};
    vecs[1] = '{2'd1, 16'd1, 4'b0011, 4};
    vecs[2] = '{2'd2, 16'd2, 4'b0111, 8};
    vecs[3] = '{2'd3, 16'd5, 4'b1111, 20};

    rst = 1; cfg_we = 0; cfg_ch = 0; cfg_period = 0; ch_en = 0;
    clear_stats();
    run(2);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_ack", int'(cfg_ack), 0);
    check("rst_base", int'(base_tick), 0);
    check("rst_tick", int'(tick_out), 0);

    // Release with no writes: base ticks at cycles 4, 8, 12 only.
    rst = 0;
    bmask = 0;
    for (int k = 1; k <= 13; k++) begin
      tick_cycle();
      if (base_tick) bmask |= (1 << k);
    end
    check("base_mask", bmask, 32'h1110);
    check("idle_ticks", ntick[0] + ntick[1] + ntick[2] + ntick[3], 0);
    check("idle_ready", int'(cfg_ready), 1);

    for (int v = 0; v < 4; v++) begin
      ch_en = vecs[v].en;
      do_write(vecs[v].ch, vecs[v].per);
      clear_stats();
      run(3 * vecs[v].interval + 4);
      check($sformatf("interval_ch%0d", vecs[v].ch),
            last_tick[vecs[v].ch] - prev_tick[vecs[v].ch], vecs[v].interval);
    end
    check("ch1_ch2_coincide", nocoinc, 0);

    // Second write during PEND is dropped.
    wait_ready();
    g = 0;
    while (!base_tick && g < 10) begin tick_cycle(); g++; end
    check("found_base", int'(base_tick), 1);
    clear_stats();
    cfg_we = 1; cfg_ch = 0; cfg_period = 16'd6;
    tick_cycle();
    check("pend_not_ready", int'(cfg_ready), 0);
    cfg_period = 16'd2;
    tick_cycle();
    cfg_we = 0;
    run(12);
    check("single_ack", nack, 1);
    clear_stats();
    run(76);
    check("first_write_wins", last_tick[0] - prev_tick[0], 24);

    // Enable drop mid-period, then re-enable away from a base tick.
    g = 0;
    while (!tick_out[0] && g < 40) begin tick_cycle(); g++; end
    run(8);
    ch_en[0] = 0;
    clear_stats();
    run(40);
    check("disabled_no_tick", ntick[0], 0);
    g = 0;
    while (base_tick && g < 4) begin tick_cycle(); g++; end
    ch_en[0] = 1;
    bases = 0; prev_base = 0;
    g = 0;
    tick_cycle();
    while (!tick_out[0] && g < 60) begin
      bases += int'(base_tick); prev_base = base_tick; tick_cycle(); g++;
    end
    check("reenable_bases", bases, 6);
    check("reenable_tick_after_base", int'(prev_base), 1);

    // Reset while a ch3 write is pending discards it.
    wait_ready();
    cfg_we = 1; cfg_ch = 3; cfg_period = 16'd5;
    tick_cycle();
    cfg_we = 0;
    check("pend_before_rst", int'(cfg_ready), 0);
    rst = 1;
    run(2);
    rst = 0;
    check("post_rst_ready", int'(cfg_ready), 1);
    ch_en = 4'b1111;
    clear_stats();
    run(60);
    check("post_rst_no_ack", nack, 0);
    check("post_rst_no_tick3", ntick[3], 0);

    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 299) == 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       cfg_period = 16'd0;
        1:       cfg_period = 16'hFFFF;
        default: cfg_period = 16'($urandom_range(1, 5));
      endcase
      if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom_range(0, 15));
      tick_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
